// File: rtl/rtl_cnt_seg.sv
// Segmented up/down counter with synchronous load. Each segment keeps registered
// all-ones/all-zeros flags, so a segment's carry-in is an AND of registered flags.
module rtl_cnt_seg #(
    parameter int N   = 17,
    parameter int SEG = 4
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         cin,
    input  logic         dir,
    input  logic         load,
    input  logic [N-1:0] din,
    output logic [N-1:0] cnt,
    output logic         cout
);

    localparam int SEGW = (SEG > N) ? N : SEG;
    localparam int NSEG = (N + SEGW - 1) / SEGW;

    logic [NSEG-1:0] ones_q;
    logic [NSEG-1:0] zeros_q;
    logic [NSEG-1:0] ones_nxt;
    logic [NSEG-1:0] zeros_nxt;
    logic [NSEG:0]   below_ones;
    logic [NSEG:0]   below_zeros;
    logic [NSEG-1:0] seg_step;
    logic [N-1:0]    cnt_nxt;
    logic            step_en;
    logic            cout_nxt;

    assign step_en = cin & ~load;

    // Prefix ANDs of registered flags; below_*[k] covers segments 0..k-1.
    always_comb begin
        below_ones  = '0;
        below_zeros = '0;
        below_ones[0]  = 1'b1;
        below_zeros[0] = 1'b1;
        for (int k = 0; k < NSEG; k++) begin
            below_ones[k+1]  = below_ones[k] & ones_q[k];
            below_zeros[k+1] = below_zeros[k] & zeros_q[k];
        end
    end

    always_comb begin
        seg_step = '0;
        for (int k = 0; k < NSEG; k++) begin
            seg_step[k] = step_en & (dir ? below_zeros[k] : below_ones[k]);
        end
    end

    assign cout_nxt = step_en & (dir ? below_zeros[NSEG] : below_ones[NSEG]);

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        localparam int LO = k * SEGW;
        localparam int W  = ((N - LO) < SEGW) ? (N - LO) : SEGW;

        logic [W-1:0] seg_cur;
        logic [W-1:0] seg_nxt;

        assign seg_cur = cnt[LO +: W];

        always_comb begin
            seg_nxt = seg_cur;
            if (load) begin
                seg_nxt = din[LO +: W];
            end else if (seg_step[k]) begin
                seg_nxt = dir ? (seg_cur - 1'b1) : (seg_cur + 1'b1);
            end
        end

        assign cnt_nxt[LO +: W] = seg_nxt;
        assign ones_nxt[k]      = &seg_nxt;
        assign zeros_nxt[k]     = ~|seg_nxt;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt     <= '0;
            cout    <= 1'b0;
            ones_q  <= '0;
            zeros_q <= '1;
        end else begin
            cnt     <= cnt_nxt;
            cout    <= cout_nxt;
            ones_q  <= ones_nxt;
            zeros_q <= zeros_nxt;
        end
    end

endmodule

// File: tb/tb_rtl_cnt_seg.sv
// Bench for rtl_cnt_seg: four width/segment configurations driven in lockstep
// and compared against an arithmetic reference counter each cycle.
module tb_rtl_cnt_seg;

    logic        clk;
    logic        nreset;
    logic        cin;
    logic        dir;
    logic        load;
    logic [16:0] din;

    logic [16:0] cnt0, cnt1, cnt2;
    logic [7:0]  cnt3;
    logic        cout0, cout1, cout2, cout3;

    int n_checks = 0;
    int n_errors = 0;

    int unsigned m_cnt  [4];
    bit          m_cout [4];
    int unsigned m_mask [4] = '{32'h1FFFF, 32'h1FFFF, 32'h1FFFF, 32'hFF};

    rtl_cnt_seg #(.N(17), .SEG(4)) u_n17_s4 (
        .clk(clk), .nreset(nreset), .cin(cin), .dir(dir), .load(load),
        .din(din), .cnt(cnt0), .cout(cout0));
    rtl_cnt_seg #(.N(17), .SEG(1)) u_n17_s1 (
        .clk(clk), .nreset(nreset), .cin(cin), .dir(dir), .load(load),
        .din(din), .cnt(cnt1), .cout(cout1));
    rtl_cnt_seg #(.N(17), .SEG(17)) u_n17_s17 (
        .clk(clk), .nreset(nreset), .cin(cin), .dir(dir), .load(load),
        .din(din), .cnt(cnt2), .cout(cout2));
    rtl_cnt_seg #(.N(8), .SEG(3)) u_n8_s3 (
        .clk(clk), .nreset(nreset), .cin(cin), .dir(dir), .load(load),
        .din(din[7:0]), .cnt(cnt3), .cout(cout3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i]  = 0;
            m_cout[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input bit c, input bit d, input bit l, input int unsigned v);
        for (int i = 0; i < 4; i++) begin
            if (l) begin
                m_cnt[i]  = v & m_mask[i];
                m_cout[i] = 1'b0;
            end else if (c && !d) begin
                m_cout[i] = (m_cnt[i] == m_mask[i]);
                m_cnt[i]  = (m_cnt[i] + 1) & m_mask[i];
            end else if (c && d) begin
                m_cout[i] = (m_cnt[i] == 0);
                m_cnt[i]  = (m_cnt[i] - 1) & m_mask[i];
            end else begin
                m_cout[i] = 1'b0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk($sformatf("%s_cnt_n17s4", tag),  {15'b0, cnt0}, m_cnt[0]);
        chk($sformatf("%s_cout_n17s4", tag), {31'b0, cout0}, {31'b0, m_cout[0]});
        chk($sformatf("%s_cnt_n17s1", tag),  {15'b0, cnt1}, m_cnt[1]);
        chk($sformatf("%s_cout_n17s1", tag), {31'b0, cout1}, {31'b0, m_cout[1]});
        chk($sformatf("%s_cnt_n17s17", tag), {15'b0, cnt2}, m_cnt[2]);
        chk($sformatf("%s_cout_n17s17", tag), {31'b0, cout2}, {31'b0, m_cout[2]});
        chk($sformatf("%s_cnt_n8s3", tag),   {24'b0, cnt3}, m_cnt[3]);
        chk($sformatf("%s_cout_n8s3", tag),  {31'b0, cout3}, {31'b0, m_cout[3]});
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare 1 time unit later.
    task automatic cycle(input string tag, input bit c, input bit d, input bit l,
                         input logic [16:0] v);
        cin  = c;
        dir  = d;
        load = l;
        din  = v;
        @(posedge clk);
        model_edge(c, d, l, {15'b0, v});
        #1;
        check_all(tag);
    endtask

    // Load values biased toward all-ones / all-zeros nibbles so carries reach upper segments.
    function automatic logic [16:0] pick_din();
        logic [19:0] v;
        v = '0;
        for (int s = 0; s < 5; s++) begin
            case ($urandom_range(0, 3))
                0:       v[s*4 +: 4] = 4'h0;
                1, 2:    v[s*4 +: 4] = 4'hF;
                default: v[s*4 +: 4] = 4'($urandom_range(0, 15));
            endcase
        end
        return v[16:0];
    endfunction

    initial begin
        bit          rd;
        int          cout_seen;
        cin    = 1'b0;
        dir    = 1'b0;
        load   = 1'b0;
        din    = '0;
        nreset = 1'b0;
        model_reset();

        #12;
        check_all("reset");
        nreset = 1'b1;

        // Counting up from reset
        for (int i = 1; i <= 40; i++) begin
            cycle("up", 1'b1, 1'b0, 1'b0, 17'h0);
            chk("up_seq", {15'b0, cnt0}, i);
        end
        cycle("hold", 1'b0, 1'b0, 1'b0, 17'h0);
        chk("hold_val", {15'b0, cnt0}, 40);

        // Full-width wrap near the top: cout exactly once, when cnt becomes 0
        cycle("ld_top", 1'b0, 1'b0, 1'b1, 17'h1FFF0);
        cout_seen = 0;
        for (int i = 0; i < 24; i++) begin
            cycle("wrap", 1'b1, 1'b0, 1'b0, 17'h0);
            if (cout0) begin
                cout_seen++;
                chk("wrap_cnt_at_cout", {15'b0, cnt0}, 32'h0);
            end
        end
        chk("wrap_cout_once", cout_seen, 1);

        // Carry across the 16-bit boundary
        cycle("ld_0ffff", 1'b0, 1'b0, 1'b1, 17'h0FFFF);
        cycle("up_10000", 1'b1, 1'b0, 1'b0, 17'h0);
        chk("t2_cnt", {15'b0, cnt0}, 32'h10000);
        chk("t2_cout", {31'b0, cout0}, 32'h0);
        cycle("ld_1fffe", 1'b0, 1'b0, 1'b1, 17'h1FFFE);
        cycle("up_1ffff", 1'b1, 1'b0, 1'b0, 17'h0);
        chk("t2_cnt_1ffff", {15'b0, cnt0}, 32'h1FFFF);
        cycle("up_wrap", 1'b1, 1'b0, 1'b0, 17'h0);
        chk("t2_cnt_wrap", {15'b0, cnt0}, 32'h0);
        chk("t2_cout_wrap", {31'b0, cout0}, 32'h1);

        // Borrow across segments and underflow
        cycle("ld_10000", 1'b0, 1'b0, 1'b1, 17'h10000);
        cycle("dn_0ffff", 1'b1, 1'b1, 1'b0, 17'h0);
        chk("t3_cnt", {15'b0, cnt0}, 32'h0FFFF);
        cycle("ld_3", 1'b0, 1'b0, 1'b1, 17'h00003);
        for (int i = 0; i < 3; i++) cycle("dn", 1'b1, 1'b1, 1'b0, 17'h0);
        chk("t3_zero", {15'b0, cnt0}, 32'h0);
        cycle("dn_wrap", 1'b1, 1'b1, 1'b0, 17'h0);
        chk("t3_cnt_wrap", {15'b0, cnt0}, 32'h1FFFF);
        chk("t3_cout_wrap", {31'b0, cout0}, 32'h1);

        // Load beats count; then alternating direction
        cycle("ld_cin", 1'b1, 1'b0, 1'b1, 17'h00ABC);
        chk("t4_ld_cnt", {15'b0, cnt0}, 32'h00ABC);
        chk("t4_ld_cout", {31'b0, cout0}, 32'h0);
        for (int i = 0; i < 6; i++) begin
            cycle("alt_up", 1'b1, 1'b0, 1'b0, 17'h0);
            chk("t4_alt_up", {15'b0, cnt0}, 32'h00ABD);
            cycle("alt_dn", 1'b1, 1'b1, 1'b0, 17'h0);
            chk("t4_alt_dn", {15'b0, cnt0}, 32'h00ABC);
        end

        // Unknown din while load is low must not reach cnt
        cycle("din_x", 1'b1, 1'b0, 1'b0, 17'bx);
        chk("din_x_cnt", {15'b0, cnt0}, 32'h00ABD);

        // Asynchronous reset between edges
        cycle("pre_rst", 1'b0, 1'b0, 1'b1, 17'h1FFFF);
        cycle("pre_rst_up", 1'b1, 1'b0, 1'b0, 17'h0);
        #2;
        nreset = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        #1;
        nreset = 1'b1;
        cycle("post_rst", 1'b1, 1'b0, 1'b0, 17'h0);
        chk("post_rst_cnt", {15'b0, cnt0}, 32'h1);

        // Randomized traffic, all four configurations in lockstep
        rd = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            bit c, l;
            logic [16:0] v;
            if ($urandom_range(0, 3) == 0) rd = ~rd;
            c = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 15) == 0);
            v = pick_din();
            cycle("rand", c, rd, l, v);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
